// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and widths for the multiplier reduce stage
package mul_pkg;

    localparam int XLEN   = 32;
    localparam int PWIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    // [1] = operand A negative, [0] = operand B negative
    typedef logic [1:0] sign_t;

endpackage

// File: rtl/mul_lane_adder.sv
// rtl/mul_lane_adder.sv - combinational modulo-2^64 sum of LANES partial words
module mul_lane_adder
    import mul_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [LANES*PWIDTH-1:0] i_words,
    output logic [PWIDTH-1:0]       o_sum
);

    always_comb begin
        o_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            o_sum = o_sum + i_words[k*PWIDTH +: PWIDTH];
        end
    end

endmodule

// File: rtl/mul_reduce.sv
// rtl/mul_reduce.sv - accumulates partial products LANES per cycle, sign-corrects, returns a 32-bit half
module mul_reduce
    import mul_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [PWIDTH*SIZE-1:0] partial_i,
    input  logic [1:0]             sign_i,
    input  logic                   higher_i,
    input  logic                   clear_i,
    output logic                   ready_o,
    output logic                   valid_o,
    output logic [XLEN-1:0]        result_o
);

    localparam int NGRP = SIZE / LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    if ((LANES < 1) || (SIZE < LANES) || (SIZE % LANES != 0)) begin : g_cfg_err
        $error("mul_reduce: SIZE must be a non-zero multiple of LANES");
    end

    state_t                 r_state;
    logic [PWIDTH*SIZE-1:0] r_partials;
    sign_t                  r_sign;
    logic                   r_higher;
    logic [PWIDTH-1:0]      r_acc;
    logic [GW-1:0]          r_grp;
    logic                   r_valid;
    logic [XLEN-1:0]        r_result;

    logic [LANES*PWIDTH-1:0] w_lanes;
    logic [PWIDTH-1:0]       w_lane_sum;
    logic [PWIDTH-1:0]       w_prod;
    logic                    w_last_grp;

    assign w_lanes    = r_partials[r_grp*(LANES*PWIDTH) +: LANES*PWIDTH];
    assign w_last_grp = (r_grp == GW'(NGRP - 1));
    // Like signs cancel: only a single negative operand flips the product
    assign w_prod     = (r_sign[1] ^ r_sign[0]) ? (~r_acc + 64'd1) : r_acc;

    mul_lane_adder #(
        .LANES (LANES)
    ) u_lane_adder (
        .i_words (w_lanes),
        .o_sum   (w_lane_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_partials <= '0;
            r_sign     <= '0;
            r_higher   <= 1'b0;
            r_acc      <= '0;
            r_grp      <= '0;
            r_valid    <= 1'b0;
            r_result   <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_partials <= partial_i;
                        r_sign     <= sign_i;
                        r_higher   <= higher_i;
                        r_acc      <= '0;
                        r_grp      <= '0;
                        r_state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + w_lane_sum;
                    r_grp <= r_grp + 1'b1;
                    if (w_last_grp) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_result <= r_higher ? w_prod[PWIDTH-1:XLEN] : w_prod[XLEN-1:0];
                    r_valid  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule

// File: tb/tb_mul_reduce.sv
// tb/tb_mul_reduce.sv - scoreboard bench for mul_reduce
module tb_mul_reduce;

    localparam int SIZE  = 16;
    localparam int LANES = 4;
    localparam int W     = 64 * SIZE;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [W-1:0]  partial_i;
    logic [1:0]    sign_i;
    logic          higher_i;
    logic          clear_i;
    logic          ready_o;
    logic          valid_o;
    logic [31:0]   result_o;

    int            n_tests;
    int            n_fail;
    int            n_valid;
    logic [31:0]   sb[$];
    logic [31:0]   last_exp;

    mul_reduce #(.SIZE(SIZE), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .partial_i (partial_i),
        .sign_i    (sign_i),
        .higher_i  (higher_i),
        .clear_i   (clear_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .result_o  (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [63:0] word);
        logic [W-1:0] v;
        for (int k = 0; k < SIZE; k++) v[k*64 +: 64] = word;
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [W-1:0] parts, input logic [1:0] sg, input logic hi);
        logic [63:0] s;
        s = 64'd0;
        for (int k = 0; k < SIZE; k++) s = s + parts[k*64 +: 64];
        if (sg[1] ^ sg[0]) s = 64'd0 - s;
        return hi ? s[63:32] : s[31:0];
    endfunction

    always @(negedge clk) begin
        if (valid_o) begin
            n_valid++;
            if (sb.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
            else check("result", {32'd0, result_o}, {32'd0, sb.pop_front()});
        end
    end

    // Called at a negedge; the following posedge is the start edge E0
    task automatic start_op(input logic [W-1:0] parts, input logic [1:0] sg, input logic hi,
                            input logic push, input logic [31:0] exp);
        start_i   = 1'b1;
        partial_i = parts;
        sign_i    = sg;
        higher_i  = hi;
        if (push) begin
            sb.push_back(exp);
            last_exp = exp;
        end
        @(negedge clk);
        start_i   = 1'b0;
        partial_i = {SIZE*2{$urandom()}};
        sign_i    = 2'($urandom());
        higher_i  = 1'($urandom());
    endtask

    task automatic wait_valid(input int n0, input string tag);
        int n;
        n = n0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n), 64'd5);
    endtask

    logic [W-1:0] p15;
    logic [W-1:0] rp;
    logic [1:0]   rs;
    logic         rh;
    int           v0;

    initial begin
        n_tests = 0; n_fail = 0; n_valid = 0; last_exp = 32'd0;
        rst_n = 1'b0; start_i = 1'b0; partial_i = '0; sign_i = 2'b00;
        higher_i = 1'b0; clear_i = 1'b0;
        p15 = '0;
        p15[63:0] = 64'd15;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned low half, with busy window and latency
        start_op(p15, 2'b00, 1'b0, 1'b1, 32'h0000_000F);
        for (int i = 0; i < 5; i++) begin
            check("ready_busy", 64'(ready_o), 64'd0);
            check("valid_early", 64'(valid_o), 64'd0);
            @(negedge clk);
        end
        check("valid_at_e5", 64'(valid_o), 64'd1);
        check("ready_at_e5", 64'(ready_o), 64'd1);
        @(negedge clk);
        check("valid_one_cycle", 64'(valid_o), 64'd0);

        // Sign handling (each start issued in the previous valid cycle)
        start_op(p15, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFF1);
        wait_valid(0, "lat_neg_lo");
        start_op(p15, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFFF);
        wait_valid(0, "lat_neg_hi");
        start_op(p15, 2'b11, 1'b0, 1'b1, 32'h0000_000F);
        wait_valid(0, "lat_pos11");
        start_op(p15, 2'b01, 1'b0, 1'b1, 32'hFFFF_FFF1);
        wait_valid(0, "lat_neg01");

        // All groups contribute; modular wrap
        start_op(fill(64'h0000_0001_0000_0000), 2'b00, 1'b1, 1'b1, 32'h0000_0010);
        wait_valid(0, "lat_allgrp");
        start_op(fill(64'hFFFF_FFFF_FFFF_FFFF), 2'b00, 1'b0, 1'b1, 32'hFFFF_FFF0);
        wait_valid(0, "lat_wrap");

        // Random bundles against the arithmetic model
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < SIZE; k++) rp[k*64 +: 64] = {$urandom(), $urandom()};
            rs = 2'($urandom());
            rh = 1'($urandom());
            start_op(rp, rs, rh, 1'b1, model(rp, rs, rh));
            wait_valid(0, "lat_rand");
        end

        // A start while busy is dropped
        @(negedge clk);
        v0 = n_valid;
        start_op(p15, 2'b00, 1'b1, 1'b1, 32'h0000_0000);
        @(negedge clk);
        start_i = 1'b1;
        partial_i = fill(64'd7);
        @(negedge clk);
        start_i = 1'b0;
        wait_valid(2, "lat_busy");
        repeat (8) @(negedge clk);
        check("busy_one_valid", 64'(n_valid - v0), 64'd1);
        check("busy_sb_empty", 64'(sb.size()), 64'd0);

        // Flush mid-operation
        v0 = n_valid;
        start_op(fill(64'd3), 2'b00, 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("flush_ready", 64'(ready_o), 64'd1);
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_result", 64'(result_o), 64'(last_exp));
        repeat (8) @(negedge clk);
        check("flush_no_valid", 64'(n_valid - v0), 64'd0);

        // Clear wins over start in the same cycle
        start_i = 1'b1;
        clear_i = 1'b1;
        partial_i = fill(64'd9);
        @(negedge clk);
        start_i = 1'b0;
        clear_i = 1'b0;
        check("clr_start_ready", 64'(ready_o), 64'd1);
        repeat (8) @(negedge clk);
        check("clr_start_no_valid", 64'(n_valid - v0), 64'd0);
        check("clr_start_result", 64'(result_o), 64'(last_exp));

        // Reset at E2, then a clean operation
        start_op(fill(64'h1234), 2'b00, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_result", 64'(result_o), 64'd0);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(p15, 2'b00, 1'b0, 1'b1, 32'h0000_000F);
        wait_valid(0, "lat_after_rst");
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
